dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-master arbiter sharing the single data-memory/peripheral bus (the memory-mux master port) between the core data port (master 0) and a second bus master such as a DMA or debug loader (master 1).
- Grant is combinational per cycle. Policy is round-robin or fixed-priority. Lock-based bursts are supported, with a forced release after MAX_BURST beats.
- Read data returns after a fixed latency and is routed back to the master that issued the read.
- Sits between the masters and the memory mux in the top level, in the dmem clock domain.

Parameters:
- RR, 1, arbitration policy: 1 = round-robin, 0 = fixed priority with master 0 winning.
- RD_LATENCY, 1, slave read latency in cycles. Legal values 0..2: 0 for synthesized memory, 1 for BSRAM.
- MAX_BURST, 8, maximum consecutive locked beats per master. Legal range 1..255.

Ports:
- clk  in  1  dmem-domain clock
- rst_n  in  1  reset: synchronous, active-low
- mN_req  in  1  (N=0,1) transfer request, held until accepted
- mN_lock  in  1  request to keep ownership after this beat
- mN_wstrb  in  4  byte write strobes; 4'b0000 = read
- mN_addr  in  32  byte address
- mN_wdata  in  32  write data
- mN_gnt  out  1  beat accepted this cycle when mN_req=1
- mN_rvalid  out  1  read data valid
- mN_rdata  out  32  read data
- s_wstrb  out  4  slave write strobes
- s_addr  out  32  slave address
- s_wdata  out  32  slave write data
- s_rdata  in  32  slave read data
- owner  out  2  debug: 0 = none, 1 = master 0, 2 = master 1

Behaviour:
- Registered state:
  - owner_q (NONE/M0/M1)
  - last_q (last granted master)
  - cnt_q (8-bit count of locked beats)
  - force_q (forced-release flag)
  - a RD_LATENCY-deep tag pipeline of {valid, master}
- Reset values: owner_q=NONE, last_q=M1 (so master 0 wins first round-robin tie), cnt_q=0, force_q=0, tag pipeline cleared, all gnt/rvalid=0, all rdata=0, all slave outputs=0. No output is X after reset.
- Grant decision (combinational, evaluated in this order):
  1. If owner_q≠NONE, the owner's req=1, and cnt_q<MAX_BURST: grant the owner. The other master is blocked.
  2. Else if both masters request:
     - if force_q=1: grant the master that is not last_q, regardless of RR;
     - else if RR=1: grant the master that is not last_q;
     - else: grant master 0.
  3. Else grant the single requester.
  4. Else no grant.
- At most one gnt is high per cycle. gnt is never high without the matching req.
- Slave muxing: the granted master's wstrb/addr/wdata drive the s_* outputs in the same cycle. With no grant, s_wstrb=0, s_addr=0 and s_wdata=0, so no spurious writes occur.
- On an accepted beat by master G:
  - last_q<=G.
  - If mG_lock=1:
    - owner_q<=G;
    - cnt_q<=cnt_q+1 if owner_q was already G, else cnt_q<=1.
  - If mG_lock=0: owner_q<=NONE and cnt_q<=0.
  - force_q<=1 if the new cnt_q equals MAX_BURST, else force_q<=0.
- Forced release:
  - When cnt_q==MAX_BURST, owner_q is cleared on the next cycle it is evaluated.
  - The holder may re-win only if the other master is not requesting.
- Owner abandonment: if the owner drops req while locked, ownership is released immediately in that cycle (normal arbitration applies). owner_q<=NONE and cnt_q<=0 even with no accept.
- Read return:
  - An accepted beat with wstrb==0 pushes {1,G} into the tag pipeline.
  - RD_LATENCY cycles later, mG_rvalid=1 and mG_rdata=s_rdata for exactly one cycle. The other master's rdata is 0.
  - RD_LATENCY=0: rvalid is in the same cycle as gnt.
  - Writes produce no rvalid.
- Back-to-back beats: reads from alternating masters on consecutive cycles each return in order, one per cycle, with no bubbles.
- Reset mid-operation: in-flight tags are discarded (no rvalid after reset) and any lock is dropped.
- The owner output mirrors owner_q.

Test Plan:
- Reset, then only m0 reads addr 0x10000004 with slave returning 0xDEADBEEF: m0_gnt in cycle 0, s_addr=0x10000004, m0_rvalid=1 and rdata=0xDEADBEEF at cycle 1 (RD_LATENCY=1), m1_rvalid stays 0.
- RR=1, both masters continuously request unlocked writes: grants alternate m0, m1, m0, m1 and s_wstrb follows the granted master's strobes.
- RR=0, both masters request unlocked: m0 is granted every cycle and m1_gnt stays 0.
- MAX_BURST=4, m0 locked with req held, m1 requesting: m0 is granted 4 consecutive cycles, then m1 is granted in cycle 5 (also with RR=0); owner goes 1→1→1→1→2 if m1 locks.
- m1 holds a lock and then drops req mid-burst while m0 requests: m0 is granted in the same cycle and owner becomes 0 or 1 per m0_lock.
- m0 issues a read, then rst_n=0 in the following cycle: no rvalid is seen afterwards, and all outputs and owner read 0 during and after reset.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter for the shared data-memory/peripheral bus.
// Master 0 is the core data port, master 1 a DMA or debug loader. The grant is
// combinational per cycle (round-robin or fixed priority) with optional locked
// bursts that are forcibly released after MAX_BURST beats. Read data returns
// RD_LATENCY cycles after the accepted beat and is routed to the issuing master.
//
// Ports
//   clk, rst_n                      dmem-domain clock, synchronous active-low reset
//   mN_req/lock/wstrb/addr/wdata    master N request side (wstrb==0 means read)
//   mN_gnt                          beat accepted this cycle
//   mN_rvalid/rdata                 read return to master N
//   s_wstrb/addr/wdata              slave request side (all zero with no grant)
//   s_rdata                         slave read data
//   owner                           debug: 0 none, 1 master 0, 2 master 1
//
// State | meaning
//   OWN_NONE | no locked owner, normal arbitration
//   OWN_M0   | master 0 holds a lock
//   OWN_M1   | master 1 holds a lock
module dmem_arbiter #(
  parameter int RR         = 1,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);
  localparam logic       RR_EN = (RR != 0);

  owner_e     owner_q, owner_d, owner_eff;
  logic       last_q, last_d;   // 0 = master 0, 1 = master 1
  logic [7:0] cnt_q, cnt_d;
  logic       force_q, force_d;

  logic owner_req;
  logic gnt0, gnt1, gsel, glock;
  logic push_v, ret_v, ret_m;

  always_comb begin
    owner_req = 1'b0;
    case (owner_q)
      OWN_M0:  owner_req = m0_req;
      OWN_M1:  owner_req = m1_req;
      default: owner_req = 1'b0;
    endcase
  end

  // Grant decision. Held in reset so nothing reaches the slave while rst_n is low.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (owner_q != OWN_NONE && owner_req && cnt_q < MAX_B) begin
        gnt0 = (owner_q == OWN_M0);
        gnt1 = (owner_q == OWN_M1);
      end else if (m0_req && m1_req) begin
        // After a forced release the other master wins even in fixed-priority mode.
        if (force_q || RR_EN) begin
          gnt0 = last_q;
          gnt1 = !last_q;
        end else begin
          gnt0 = 1'b1;
        end
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
  end

  assign gsel  = gnt1;
  assign glock = gsel ? m1_lock : m0_lock;

  always_comb begin
    // A lock is dropped as soon as its holder stops requesting or exhausts its burst.
    owner_eff = owner_q;
    if (owner_q != OWN_NONE && (!owner_req || cnt_q >= MAX_B)) begin
      owner_eff = OWN_NONE;
    end
    owner_d = owner_eff;
    cnt_d   = (owner_eff == OWN_NONE) ? 8'd0 : cnt_q;
    last_d  = last_q;
    force_d = force_q;
    if (gnt0 || gnt1) begin
      last_d = gsel;
      if (glock) begin
        owner_d = gsel ? OWN_M1 : OWN_M0;
        cnt_d   = (owner_eff == owner_d) ? cnt_q + 8'd1 : 8'd1;
      end else begin
        owner_d = OWN_NONE;
        cnt_d   = 8'd0;
      end
      force_d = (cnt_d == MAX_B);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
      force_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      force_q <= force_d;
    end
  end

  always_comb begin
    s_wstrb = 4'd0;
    s_addr  = 32'd0;
    s_wdata = 32'd0;
    if (gnt0) begin
      s_wstrb = m0_wstrb;
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
    end else if (gnt1) begin
      s_wstrb = m1_wstrb;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
    end
  end

  assign push_v = (gnt0 || gnt1) && (s_wstrb == 4'd0);

  generate
    if (RD_LATENCY == 0) begin : g_lat0
      assign ret_v = push_v;
      assign ret_m = gsel;
    end else begin : g_pipe
      logic [RD_LATENCY-1:0] tv_q, tm_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          tv_q <= '0;
          tm_q <= '0;
        end else begin
          tv_q[0] <= push_v;
          tm_q[0] <= gsel;
          for (int i = 1; i < RD_LATENCY; i++) begin
            tv_q[i] <= tv_q[i-1];
            tm_q[i] <= tm_q[i-1];
          end
        end
      end
      assign ret_v = tv_q[RD_LATENCY-1];
      assign ret_m = tm_q[RD_LATENCY-1];
    end
  endgenerate

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rst_n && ret_v && !ret_m;
  assign m1_rvalid = rst_n && ret_v && ret_m;
  assign m0_rdata  = m0_rvalid ? s_rdata : 32'd0;
  assign m1_rdata  = m1_rvalid ? s_rdata : 32'd0;
  assign owner     = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance A (round-robin, read latency 1) and instance B
// (fixed priority, read latency 0), both with MAX_BURST=4, share one stimulus.
module tb_dmem_arbiter;

  localparam int MB = 4;

  typedef struct packed {
    logic        g0, g1;
    logic [3:0]  sw;
    logic [31:0] sa, sd;
    logic        rv0, rv1;
    logic [31:0] rd0, rd1;
    logic [1:0]  own;
  } out_t;

  typedef struct packed {
    logic        rst;
    logic        r0, l0;
    logic [3:0]  w0;
    logic [31:0] a0;
    logic        r1, l1;
    logic [3:0]  w1;
    logic [31:0] a1;
    logic [31:0] sr;
  } in_t;

  typedef struct packed {
    in_t         i;
    logic        g0, g1;
    logic [3:0]  sw;
    logic [31:0] sa;
    logic        rv0;
    logic [31:0] rd0;
    logic        rv1;
    logic [1:0]  own;
  } vec_t;

  typedef struct {
    int k;
    int due;
    int m;
  } pend_t;

  logic clk = 1'b0;
  logic rst_n;
  logic m0_req, m0_lock, m1_req, m1_lock;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;

  logic        a_g0, a_g1, a_rv0, a_rv1, b_g0, b_g1, b_rv0, b_rv1;
  logic [31:0] a_rd0, a_rd1, a_sa, a_sd, b_rd0, b_rd1, b_sa, b_sd;
  logic [3:0]  a_sw, b_sw;
  logic [1:0]  a_own, b_own;
  out_t        a_out, b_out;

  always #5 clk = ~clk;

  dmem_arbiter #(.RR(1), .RD_LATENCY(1), .MAX_BURST(MB)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(a_g0), .m0_rvalid(a_rv0), .m0_rdata(a_rd0),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(a_g1), .m1_rvalid(a_rv1), .m1_rdata(a_rd1),
    .s_wstrb(a_sw), .s_addr(a_sa), .s_wdata(a_sd), .s_rdata(s_rdata), .owner(a_own)
  );

  dmem_arbiter #(.RR(0), .RD_LATENCY(0), .MAX_BURST(MB)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(b_g0), .m0_rvalid(b_rv0), .m0_rdata(b_rd0),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(b_g1), .m1_rvalid(b_rv1), .m1_rdata(b_rd1),
    .s_wstrb(b_sw), .s_addr(b_sa), .s_wdata(b_sd), .s_rdata(s_rdata), .owner(b_own)
  );

  assign a_out = '{g0:a_g0, g1:a_g1, sw:a_sw, sa:a_sa, sd:a_sd, rv0:a_rv0, rv1:a_rv1,
                   rd0:a_rd0, rd1:a_rd1, own:a_own};
  assign b_out = '{g0:b_g0, g1:b_g1, sw:b_sw, sa:b_sa, sd:b_sd, rv0:b_rv0, rv1:b_rv1,
                   rd0:b_rd0, rd1:b_rd1, own:b_own};

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;

  // Reference model state per instance: owner -1/0/1, beats in current lock,
  // last granted master, forced-release flag, and outstanding read returns.
  int    m_owner[2], m_cnt[2], m_last[2];
  bit    m_frc[2];
  int    p_rr[2]  = '{1, 0};
  int    p_lat[2] = '{1, 0};
  pend_t pq[$];

  function automatic void model_reset(int k);
    pend_t keep[$];
    m_owner[k] = -1;
    m_cnt[k]   = 0;
    m_last[k]  = 1;
    m_frc[k]   = 1'b0;
    foreach (pq[j]) if (pq[j].k != k) keep.push_back(pq[j]);
    pq = keep;
  endfunction

  task automatic model_step(input int k, input out_t act);
    out_t        e;
    int          g, rvm, o, eff;
    int          req[2], lck[2];
    logic [3:0]  ws[2];
    logic [31:0] ad[2], wd[2];
    pend_t       keep[$];
    pend_t       p;
    req = '{int'(m0_req), int'(m1_req)};
    lck = '{int'(m0_lock), int'(m1_lock)};
    ws  = '{m0_wstrb, m1_wstrb};
    ad  = '{m0_addr, m1_addr};
    wd  = '{m0_wdata, m1_wdata};
    e   = '0;
    g   = -1;
    rvm = -1;
    o   = m_owner[k];
    if (rst_n) begin
      if (o >= 0 && req[o] != 0 && m_cnt[k] < MB) g = o;
      else if (req[0] != 0 && req[1] != 0) g = (m_frc[k] || p_rr[k] != 0) ? 1 - m_last[k] : 0;
      else if (req[0] != 0) g = 0;
      else if (req[1] != 0) g = 1;
    end
    if (g >= 0) begin
      e.g0 = (g == 0);
      e.g1 = (g == 1);
      e.sw = ws[g];
      e.sa = ad[g];
      e.sd = wd[g];
    end
    if (rst_n) begin
      if (p_lat[k] == 0) begin
        if (g >= 0 && ws[g] == 4'd0) rvm = g;
      end else begin
        foreach (pq[j]) if (pq[j].k == k && pq[j].due == cyc) rvm = pq[j].m;
      end
    end
    if (rvm == 0) begin e.rv0 = 1'b1; e.rd0 = s_rdata; end
    if (rvm == 1) begin e.rv1 = 1'b1; e.rd1 = s_rdata; end
    e.own = (o < 0) ? 2'd0 : 2'(o + 1);
    nvec++;
    if (act !== e) begin
      nmis++;
      $display("FAIL model_%s cyc %0d: got %h want %h", (k == 0) ? "a" : "b", cyc, act, e);
    end
    if (!rst_n) begin
      model_reset(k);
    end else begin
      eff = o;
      if (o >= 0 && (req[o] == 0 || m_cnt[k] >= MB)) eff = -1;
      if (eff < 0) begin
        m_owner[k] = -1;
        m_cnt[k]   = 0;
      end
      if (g >= 0) begin
        m_last[k] = g;
        if (lck[g] != 0) begin
          m_cnt[k]   = (eff == g) ? m_cnt[k] + 1 : 1;
          m_owner[k] = g;
        end else begin
          m_cnt[k]   = 0;
          m_owner[k] = -1;
        end
        m_frc[k] = (m_cnt[k] == MB);
        if (ws[g] == 4'd0 && p_lat[k] > 0) begin
          p.k = k; p.due = cyc + p_lat[k]; p.m = g;
          pq.push_back(p);
        end
      end
      foreach (pq[j]) if (!(pq[j].k == k && pq[j].due <= cyc)) keep.push_back(pq[j]);
      pq = keep;
    end
  endtask

  task automatic drive(input in_t v);
    rst_n    = v.rst;
    m0_req   = v.r0;  m0_lock = v.l0;  m0_wstrb = v.w0;  m0_addr = v.a0;
    m0_wdata = v.a0 ^ 32'h5A5A_0000;
    m1_req   = v.r1;  m1_lock = v.l1;  m1_wstrb = v.w1;  m1_addr = v.a1;
    m1_wdata = ~v.a1;
    s_rdata  = v.sr;
  endtask

  task automatic step(input in_t v);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    model_step(0, a_out);
    model_step(1, b_out);
    cyc++;
  endtask

  function automatic in_t mkin(logic rst, logic r0, logic l0, logic [3:0] w0, logic [31:0] a0,
                               logic r1, logic l1, logic [3:0] w1, logic [31:0] a1,
                               logic [31:0] sr);
    in_t v;
    v = '{rst:rst, r0:r0, l0:l0, w0:w0, a0:a0, r1:r1, l1:l1, w1:w1, a1:a1, sr:sr};
    return v;
  endfunction

  function automatic vec_t mkv(in_t i, logic g0, logic g1, logic [3:0] sw, logic [31:0] sa,
                               logic rv0, logic [31:0] rd0, logic rv1, logic [1:0] own);
    vec_t v;
    v = '{i:i, g0:g0, g1:g1, sw:sw, sa:sa, rv0:rv0, rd0:rd0, rv1:rv1, own:own};
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s cyc %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  vec_t        tab[23];
  in_t         idle, both_wr, brst, rd1;
  logic [73:0] got_v, exp_v;

  initial begin
    idle = mkin(1, 0, 0, 4'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    // Directed table, expectations for instance A (RR=1, latency 1, burst 4).
    tab[0]  = mkv(mkin(0, 0,0,4'h0,32'h0,        0,0,4'h0,32'h0,   32'h0),       0,0,4'h0,32'h0,        0,32'h0,0,2'd0);
    tab[1]  = mkv(mkin(1, 1,0,4'h0,32'h10000004, 0,0,4'h0,32'h0,   32'h11111111),1,0,4'h0,32'h10000004, 0,32'h0,0,2'd0);
    tab[2]  = mkv(mkin(1, 0,0,4'h0,32'h0,        0,0,4'h0,32'h0,   32'hDEADBEEF),0,0,4'h0,32'h0,        1,32'hDEADBEEF,0,2'd0);
    tab[3]  = mkv(mkin(1, 1,0,4'h3,32'h100,      1,0,4'hC,32'h200, 32'h0),       0,1,4'hC,32'h200,      0,32'h0,0,2'd0);
    tab[4]  = mkv(tab[3].i,                                                      1,0,4'h3,32'h100,      0,32'h0,0,2'd0);
    tab[5]  = mkv(tab[3].i,                                                      0,1,4'hC,32'h200,      0,32'h0,0,2'd0);
    tab[6]  = mkv(tab[3].i,                                                      1,0,4'h3,32'h100,      0,32'h0,0,2'd0);
    tab[7]  = mkv(mkin(1, 0,0,4'h0,32'h0,        1,0,4'hC,32'h200, 32'h0),       0,1,4'hC,32'h200,      0,32'h0,0,2'd0);
    tab[8]  = mkv(mkin(1, 1,1,4'hF,32'h104,      1,0,4'h1,32'h204, 32'h0),       1,0,4'hF,32'h104,      0,32'h0,0,2'd0);
    tab[9]  = mkv(tab[8].i,                                                      1,0,4'hF,32'h104,      0,32'h0,0,2'd1);
    tab[10] = mkv(tab[8].i,                                                      1,0,4'hF,32'h104,      0,32'h0,0,2'd1);
    tab[11] = mkv(tab[8].i,                                                      1,0,4'hF,32'h104,      0,32'h0,0,2'd1);
    tab[12] = mkv(mkin(1, 1,1,4'hF,32'h104,      1,1,4'h1,32'h204, 32'h0),       0,1,4'h1,32'h204,      0,32'h0,0,2'd1);
    tab[13] = mkv(mkin(1, 1,0,4'h2,32'h108,      0,0,4'h0,32'h0,   32'h0),       1,0,4'h2,32'h108,      0,32'h0,0,2'd2);
    tab[14] = mkv(idle,                                                          0,0,4'h0,32'h0,        0,32'h0,0,2'd0);
    tab[15] = mkv(mkin(1, 0,0,4'h0,32'h0,        1,1,4'h4,32'h20C, 32'h0),       0,1,4'h4,32'h20C,      0,32'h0,0,2'd0);
    tab[16] = mkv(mkin(1, 1,1,4'h8,32'h10C,      0,0,4'h0,32'h0,   32'h0),       1,0,4'h8,32'h10C,      0,32'h0,0,2'd2);
    tab[17] = mkv(idle,                                                          0,0,4'h0,32'h0,        0,32'h0,0,2'd1);
    tab[18] = mkv(idle,                                                          0,0,4'h0,32'h0,        0,32'h0,0,2'd0);
    tab[19] = mkv(mkin(1, 1,0,4'h0,32'h20,       0,0,4'h0,32'h0,   32'h0),       1,0,4'h0,32'h20,       0,32'h0,0,2'd0);
    tab[20] = mkv(mkin(0, 1,0,4'h0,32'h20,       0,0,4'h0,32'h0,   32'h12345678),0,0,4'h0,32'h0,        0,32'h0,0,2'd0);
    tab[21] = mkv(mkin(1, 0,0,4'h0,32'h0,        0,0,4'h0,32'h0,   32'hCAFEF00D),0,0,4'h0,32'h0,        0,32'h0,0,2'd0);
    tab[22] = mkv(tab[21].i,                                                     0,0,4'h0,32'h0,        0,32'h0,0,2'd0);

    drive(mkin(0, 0,0,4'h0,32'h0, 0,0,4'h0,32'h0, 32'h0));
    repeat (3) @(posedge clk);
    model_reset(0);
    model_reset(1);

    for (int i = 0; i < 23; i++) begin
      step(tab[i].i);
      got_v = {a_out.g0, a_out.g1, a_out.sw, a_out.sa, a_out.rv0, a_out.rd0, a_out.rv1, a_out.own};
      exp_v = {tab[i].g0, tab[i].g1, tab[i].sw, tab[i].sa, tab[i].rv0, tab[i].rd0, tab[i].rv1, tab[i].own};
      chk($sformatf("table_row%0d", i), 128'(got_v), 128'(exp_v));
    end

    // Instance B, fixed priority: master 0 wins every contended unlocked beat.
    both_wr = mkin(1, 1,0,4'h3,32'h300, 1,0,4'hC,32'h400, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step(both_wr);
      chk("rr0_fixed", 128'({b_out.g0, b_out.g1}), 128'(2'b10));
    end

    // Instance B, fixed priority: forced release hands the bus to master 1 on beat 5.
    step(idle);
    brst = mkin(1, 1,1,4'hF,32'h500, 1,0,4'h1,32'h600, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(brst);
      chk($sformatf("rr0_burst_beat%0d", i), 128'({b_out.g0, b_out.g1}),
          128'((i == 4) ? 2'b01 : 2'b10));
    end

    // Instance B, zero latency: read data is returned in the grant cycle.
    rd1 = mkin(1, 0,0,4'h0,32'h0, 1,0,4'h0,32'h700, 32'h0BADF00D);
    step(rd1);
    chk("lat0_read", 128'({b_out.g1, b_out.rv1, b_out.rd1, b_out.rv0, b_out.rd0}),
        128'({1'b1, 1'b1, 32'h0BADF00D, 1'b0, 32'h0}));

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      in_t v;
      v.rst = ($urandom_range(0, 99) != 0);
      v.r0  = ($urandom_range(0, 9) < 7);
      v.l0  = ($urandom_range(0, 3) != 0);
      v.w0  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      v.a0  = $urandom;
      v.r1  = ($urandom_range(0, 9) < 7);
      v.l1  = ($urandom_range(0, 3) != 0);
      v.w1  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      v.a1  = $urandom;
      v.sr  = $urandom;
      step(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
